// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter (CPU and debug/loader) in front of a single-port RAM with registered read data.
// Optional CPU write protection of the 0x7800-0x7FFF window is enabled with macro RAM_ARB_WPROT_EN.
module ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef RAM_ARB_WPROT_EN
   output logic              wp_err,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state;
   logic              owner;      // 0 = CPU, 1 = DBG
   logic              last;       // owner of the most recent granted access
   logic              pick;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              wr_block;
   logic [DATA_W-1:0] cpu_hold;
   logic [DATA_W-1:0] dbg_hold;

   // NOTE: every signal written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      pick      = dbg_req;
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (cpu_req && dbg_req) begin
         pick = ~last;
      end
      if (pick) begin
         sel_we    = dbg_we;
         sel_addr  = dbg_addr;
         sel_wdata = dbg_wdata;
      end
   end

`ifdef RAM_ARB_WPROT_EN
   localparam logic [ADDR_W-12:0] WP_TAG = {1'b0, {(ADDR_W-12){1'b1}}};

   logic prot_q;

   assign wr_block = ~pick & cpu_we & (cpu_addr[ADDR_W-1:11] == WP_TAG);
`else
   assign wr_block = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= '0;
         dbg_hold  <= '0;
`ifdef RAM_ARB_WPROT_EN
         prot_q    <= 1'b0;
         wp_err    <= 1'b0;
`endif
      end else begin
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
`ifdef RAM_ARB_WPROT_EN
         wp_err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cpu_req || dbg_req) begin
                  owner     <= pick;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we & ~wr_block;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
`ifdef RAM_ARB_WPROT_EN
                  prot_q    <= wr_block;
`endif
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // Ack is raised in the cycle the RAM presents its registered read data.
               cpu_ack <= ~owner;
               dbg_ack <= owner;
`ifdef RAM_ARB_WPROT_EN
               wp_err  <= prot_q;
`endif
               state   <= RESP;
            end
            RESP: begin
               if (owner) begin
                  dbg_hold <= mem_rdata;
               end else begin
                  cpu_hold <= mem_rdata;
               end
               last  <= owner;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read data passes straight through during the ack cycle and is held afterwards.
   assign cpu_rdata = cpu_ack ? mem_rdata : cpu_hold;
   assign dbg_rdata = dbg_ack ? mem_rdata : dbg_hold;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model plus per-cycle compare, directed vectors.
// Builds with or without RAM_ARB_WPROT_EN.
module tb_ram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr, dbg_addr;
   logic [7:0]  cpu_wdata, dbg_wdata;
   logic        cpu_ack, dbg_ack;
   logic [7:0]  cpu_rdata, dbg_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        wp_err;

   int vectors = 0;
   int errors  = 0;

   ram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef RAM_ARB_WPROT_EN
      .wp_err(wp_err),
`endif
      .busy(busy)
   );

`ifndef RAM_ARB_WPROT_EN
   assign wp_err = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM device: synchronous, read-first, registered read data.
   logic [7:0] ram [0:65535];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_wp(input logic [15:0] a);
`ifdef RAM_ARB_WPROT_EN
      return a[15:11] == 5'b01111;
`else
      return 1'b0;
`endif
   endfunction

   // Transaction model: phase counts cycles since grant (0 = idle, 1 = RAM cycle, 2 = ack cycle).
   logic [7:0]  ref_mem [0:65535];
   int          ph;
   logic        m_owner, m_last, m_we, m_prot;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata, m_rd;
   logic [7:0]  hold_cpu, hold_dbg;
   logic        hv_cpu, hv_dbg;
   logic        m_pick;
   logic        g_we;
   logic [15:0] g_addr;
   logic [7:0]  g_wdata;

   assign m_pick  = (cpu_req && dbg_req) ? ~m_last : dbg_req;
   assign g_we    = m_pick ? dbg_we : cpu_we;
   assign g_addr  = m_pick ? dbg_addr : cpu_addr;
   assign g_wdata = m_pick ? dbg_wdata : cpu_wdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph       <= 0;
         m_owner  <= 1'b0;
         m_last   <= 1'b1;
         m_prot   <= 1'b0;
         hold_cpu <= 8'h00;
         hold_dbg <= 8'h00;
         hv_cpu   <= 1'b1;
         hv_dbg   <= 1'b1;
      end else if (ph == 0) begin
         if (cpu_req || dbg_req) begin
            m_owner <= m_pick;
            m_we    <= g_we;
            m_addr  <= g_addr;
            m_wdata <= g_wdata;
            m_prot  <= !m_pick && g_we && in_wp(g_addr);
            m_rd    <= ref_mem[g_addr];
            if (g_we && !(!m_pick && in_wp(g_addr))) ref_mem[g_addr] <= g_wdata;
            ph      <= 1;
         end
      end else if (ph == 1) begin
         ph <= 2;
      end else begin
         m_last <= m_owner;
         ph     <= 0;
         if (!m_owner) begin
            hv_cpu <= !m_we;
            if (!m_we) hold_cpu <= m_rd;
         end else begin
            hv_dbg <= !m_we;
            if (!m_we) hold_dbg <= m_rd;
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      check("busy", busy, ph != 0);
      check("mem_en", mem_en, ph == 1);
      check("mem_we", mem_we, ph == 1 && m_we && !m_prot);
      if (ph == 1) begin
         check("mem_addr", mem_addr, m_addr);
         check("mem_wdata", mem_wdata, m_wdata);
      end
      check("cpu_ack", cpu_ack, ph == 2 && !m_owner);
      check("dbg_ack", dbg_ack, ph == 2 && m_owner);
      check("wp_err", wp_err, ph == 2 && m_prot);
      if (ph == 2 && !m_owner) begin
         if (!m_we) check("cpu_rdata", cpu_rdata, m_rd);
      end else if (hv_cpu) begin
         check("cpu_rdata_hold", cpu_rdata, hold_cpu);
      end
      if (ph == 2 && m_owner) begin
         if (!m_we) check("dbg_rdata", dbg_rdata, m_rd);
      end else if (hv_dbg) begin
         check("dbg_rdata_hold", dbg_rdata, hold_dbg);
      end
   end

   task automatic xfer(input bit port, input logic we, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic en1, output logic we1,
                       output logic [15:0] a1, output logic wp);
      bit got;
      int lat;
      got = 1'b0; lat = 0; rd = '0; en1 = 1'b0; we1 = 1'b0; a1 = '0; wp = 1'b0;
      @(posedge clk); #2;
      if (port) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
      while (!got && lat < 10) begin
         @(posedge clk); #2;
         lat++;
         if (lat == 1) begin
            en1 = mem_en; we1 = mem_we; a1 = mem_addr;
         end
         if ((port ? dbg_ack : cpu_ack) == 1'b1) begin
            got = 1'b1;
            rd  = port ? dbg_rdata : cpu_rdata;
            wp  = wp_err;
         end
      end
      check("ack_seen", got, 1'b1);
      check("ack_latency", lat, 2);
      if (port) dbg_req = 1'b0; else cpu_req = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   logic [7:0]  rd;
   logic        en1, we1, wp;
   logic [15:0] a1;
   logic [1:0]  ack_log [0:12];
   bit          got;
   int          lat;

   initial begin
      rst_n = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_cpu_rdata", cpu_rdata, 8'h00);
      check("rst_dbg_rdata", dbg_rdata, 8'h00);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Load 0x7809 = 0xC4, then a CPU read of it.
      xfer(1'b1, 1'b1, 16'h7809, 8'hC4, rd, en1, we1, a1, wp);
      check("ld_mem_we", we1, 1'b1);
      xfer(1'b0, 1'b0, 16'h7809, 8'h00, rd, en1, we1, a1, wp);
      check("rd7809_mem_en", en1, 1'b1);
      check("rd7809_mem_addr", a1, 16'h7809);
      check("rd7809_data", rd, 8'hC4);

      // DBG write then CPU readback.
      xfer(1'b1, 1'b1, 16'h0100, 8'h3F, rd, en1, we1, a1, wp);
      check("dbgwr_mem_we", we1, 1'b1);
      check("dbgwr_mem_addr", a1, 16'h0100);
      xfer(1'b0, 1'b0, 16'h0100, 8'h00, rd, en1, we1, a1, wp);
      check("rd0100_data", rd, 8'h3F);

      // CPU write then DBG readback.
      xfer(1'b0, 1'b1, 16'h0200, 8'hA5, rd, en1, we1, a1, wp);
      check("cpuwr_mem_we", we1, 1'b1);
      xfer(1'b1, 1'b0, 16'h0200, 8'h00, rd, en1, we1, a1, wp);
      check("rd0200_data", rd, 8'hA5);

      // Both requesting continuously straight after reset.
      do_reset();
      @(posedge clk); #2;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0200;
      for (int i = 0; i <= 12; i++) begin
         @(negedge clk);
         ack_log[i] = {dbg_ack, cpu_ack};
      end
      for (int i = 0; i <= 12; i++) begin
         check($sformatf("rr_cpu_ack[%0d]", i), ack_log[i][0], (i == 2 || i == 8));
         check($sformatf("rr_dbg_ack[%0d]", i), ack_log[i][1], (i == 5 || i == 11));
      end
      @(posedge clk); #2;
      cpu_req = 0; dbg_req = 0;
      repeat (5) @(posedge clk);

      // Reset asserted during ACCESS aborts the access; request is re-granted afterwards.
      #2;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
      @(posedge clk); #2;
      check("mid_mem_en_before", mem_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_mem_en", mem_en, 1'b0);
      check("mid_mem_we", mem_we, 1'b0);
      check("mid_mem_addr", mem_addr, 16'h0000);
      check("mid_busy", busy, 1'b0);
      check("mid_cpu_ack", cpu_ack, 1'b0);
      check("mid_cpu_rdata", cpu_rdata, 8'h00);
      repeat (2) @(posedge clk);
      #2;
      check("mid_no_ack", cpu_ack, 1'b0);
      rst_n = 1'b1;
      got = 1'b0; lat = 0;
      while (!got && lat < 10) begin
         @(posedge clk); #2;
         lat++;
         if (cpu_ack) begin
            got = 1'b1;
            rd  = cpu_rdata;
         end
      end
      check("regrant_ack_seen", got, 1'b1);
      check("regrant_latency", lat, 2);
      check("regrant_data", rd, 8'h3F);
      cpu_req = 0;

      // Write-protect window: CPU write to 0x7A00.
      xfer(1'b1, 1'b1, 16'h7A00, 8'h11, rd, en1, we1, a1, wp);
      xfer(1'b0, 1'b1, 16'h7A00, 8'h55, rd, en1, we1, a1, wp);
      check("wp_mem_en", en1, 1'b1);
`ifdef RAM_ARB_WPROT_EN
      check("wp_mem_we", we1, 1'b0);
      check("wp_err_pulse", wp, 1'b1);
      xfer(1'b0, 1'b0, 16'h7A00, 8'h00, rd, en1, we1, a1, wp);
      check("wp_ram_unchanged", rd, 8'h11);
      xfer(1'b1, 1'b1, 16'h7A00, 8'h55, rd, en1, we1, a1, wp);
      check("wp_dbg_mem_we", we1, 1'b1);
      xfer(1'b0, 1'b0, 16'h7A00, 8'h00, rd, en1, we1, a1, wp);
      check("wp_dbg_written", rd, 8'h55);
`else
      check("nowp_mem_we", we1, 1'b1);
      xfer(1'b0, 1'b0, 16'h7A00, 8'h00, rd, en1, we1, a1, wp);
      check("nowp_written", rd, 8'h55);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, which is the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, which is the RAM data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req, input, 1 bit: CPU access request, held until cpu_ack.
REQ-006 SHALL have port cpu_we, input, 1 bit: CPU write (1) or read (0), held with cpu_req.
REQ-007 SHALL have port cpu_addr, input, ADDR_W bits: CPU address, held with cpu_req.
REQ-008 SHALL have port cpu_wdata, input, DATA_W bits: CPU write data, held with cpu_req.
REQ-009 SHALL have port cpu_ack, output, 1 bit: one-cycle completion pulse to the CPU.
REQ-010 SHALL have port cpu_rdata, output, DATA_W bits: CPU read data, valid while cpu_ack is high.
REQ-011 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack and dbg_rdata, with the same directions, widths and meanings as the CPU set, for the debug/loader port.
REQ-012 SHALL have ports mem_en, output, 1 bit, and mem_we, output, 1 bit: RAM enable and write strobe.
REQ-013 SHALL have ports mem_addr, output, ADDR_W bits, and mem_wdata, output, DATA_W bits, to the RAM.
REQ-014 SHALL have port mem_rdata, input, DATA_W bits: RAM read data, registered, valid one cycle after mem_en.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RESP, plus a 1-bit register owner (0 = CPU, 1 = DBG) and a 1-bit register last (the owner of the most recent granted access).
REQ-017 In IDLE with exactly one request high, SHALL grant that requester and go to ACCESS at the next edge.
REQ-018 In IDLE with both requests high, SHALL grant the requester that is not last (round-robin) and go to ACCESS.
REQ-019 In IDLE with no request, SHALL remain in IDLE with all mem_* strobes low.
REQ-020 In ACCESS, SHALL drive mem_en=1, mem_we=owner's we, mem_addr=owner's addr and mem_wdata=owner's wdata for exactly one cycle, then go to RESP.
REQ-021 In RESP, SHALL pulse the owner's ack for exactly one cycle, drive the owner's rdata from mem_rdata, update last to owner, and go to IDLE.
REQ-022 Latency SHALL be: request sampled in IDLE at edge k, mem_en high in cycle k+1, ack high in cycle k+2; minimum spacing between successive grants is 3 cycles.
REQ-023 The non-owning port's ack SHALL stay 0; its rdata SHALL hold its previous value.
REQ-024 rdata for writes SHALL be don't-care; the ack rules SHALL be identical for reads and writes.
REQ-025 A request dropped before ack is a protocol violation; the FSM SHALL still complete the started access.
REQ-026 The arbiter SHALL never assert mem_en for two accesses in consecutive cycles.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=IDLE, owner=0, last=1 (so the CPU wins the first tie), every ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dbg_rdata=0, busy=0.
REQ-028 Reset asserted mid-access SHALL abort the access with no ack issued; after release the requester is re-arbitrated from IDLE.

Configuration
REQ-029 With macro RAM_ARB_WPROT_EN defined, a CPU write whose addr[ADDR_W-1:11] equals all-ones-below-MSB pattern 0x7800–0x7FFF (addr[15:11]=5'b01111 for ADDR_W=16) SHALL proceed through all states with mem_we=0 and SHALL still be acked; DBG writes SHALL be unaffected.
REQ-030 With RAM_ARB_WPROT_EN defined, SHALL add port wp_err, output, 1 bit, pulsing high with the ack of a suppressed write; reset value 0.
REQ-031 Without RAM_ARB_WPROT_EN, all writes SHALL reach the RAM and port wp_err SHALL NOT exist.

Verification
REQ-032 CPU read only: cpu_req=1, we=0, addr=0x7809, RAM[0x7809]=0xC4 -> mem_en at k+1 with mem_addr=0x7809, then cpu_ack at k+2 with cpu_rdata=0xC4.
REQ-033 DBG write: dbg_req=1, we=1, addr=0x0100, wdata=0x3F -> mem_we=1 for 1 cycle, then dbg_ack; a following CPU read of 0x0100 returns 0x3F.
REQ-034 Both requesting continuously after reset -> grant order CPU, DBG, CPU, DBG; ack pulses 3 cycles apart, never together.
REQ-035 rst_n pulled low during ACCESS -> no ack; all outputs take their reset values immediately; the access is re-granted after release.
REQ-036 With RAM_ARB_WPROT_EN defined: CPU writes 0x55 to 0x7A00 -> mem_we=0, cpu_ack=1, wp_err=1, RAM unchanged; a DBG write to the same address -> RAM becomes 0x55.
